// File: rtl/execute.sv
// Execute stage: ALU, branch/jump resolution and memory request formatting,
// registered into a single output slot that feeds the load/store module.
module execute (
    input  logic        clk_i,
    input  logic        rst_i,
    // decode side
    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] rs2_val_i,
    input  logic [31:0] imm_i,
    input  logic        op1_pc_i,
    input  logic        op2_imm_i,
    input  logic [2:0]  alu_ctrl_i,
    input  logic        alu_alt_i,
    input  logic        result_pc4_i,
    input  logic [2:0]  branch_cond_i,
    input  logic        jalr_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic        ls_unsigned_i,
    input  logic [1:0]  ls_size_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    // lsm side
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] alu_result_o,
    output logic        enable_o,
    output logic        write_o,
    output logic [31:0] write_data_o,
    output logic [3:0]  sel_o,
    output logic        unsigned_load_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    // fetch redirect
    output logic        branch_o,
    output logic [31:0] branch_target_o
);

    logic        w_accept;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic        w_taken;
    logic [31:0] w_target;
    logic [3:0]  w_sel_base;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;

    // Slot frees up when it is empty or its content leaves this cycle.
    assign input_ready_o = output_ready_i || !output_valid_o;
    assign w_accept      = input_valid_i && input_ready_o;

    assign w_a = op1_pc_i  ? pc_i  : rs1_val_i;
    assign w_b = op2_imm_i ? imm_i : rs2_val_i;

    // ALU operation select; shift amount is the low five bits of operand b.
    always_comb begin
        w_alu = 32'd0;
        case (alu_ctrl_i)
            3'b000: w_alu = alu_alt_i ? (w_a - w_b) : (w_a + w_b);
            3'b001: w_alu = w_a << w_b[4:0];
            3'b010: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            3'b011: w_alu = {31'd0, w_a < w_b};
            3'b100: w_alu = w_a ^ w_b;
            3'b101: w_alu = alu_alt_i ? 32'($signed(w_a) >>> w_b[4:0])
                                      : (w_a >> w_b[4:0]);
            3'b110: w_alu = w_a | w_b;
            default: w_alu = w_a & w_b;
        endcase
    end

    // jal/jalr write the return address instead of the ALU output.
    assign w_result = result_pc4_i ? (pc_i + 32'd4) : w_alu;

    // Branch condition evaluation on the raw register operands.
    always_comb begin
        w_taken = 1'b0;
        case (branch_cond_i)
            3'd1: w_taken = (rs1_val_i == rs2_val_i);
            3'd2: w_taken = (rs1_val_i != rs2_val_i);
            3'd3: w_taken = ($signed(rs1_val_i) <  $signed(rs2_val_i));
            3'd4: w_taken = ($signed(rs1_val_i) >= $signed(rs2_val_i));
            3'd5: w_taken = (rs1_val_i <  rs2_val_i);
            3'd6: w_taken = (rs1_val_i >= rs2_val_i);
            3'd7: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // jalr clears bit 0 of the computed target.
    assign w_target = jalr_i ? ((rs1_val_i + imm_i) & ~32'd1) : (pc_i + imm_i);

    // Byte-lane mask by access size; size 11 behaves as a word.
    always_comb begin
        w_sel_base = 4'b1111;
        case (ls_size_i)
            2'b00:   w_sel_base = 4'b0001;
            2'b01:   w_sel_base = 4'b0011;
            default: w_sel_base = 4'b1111;
        endcase
    end

    // Lanes shifted past bit 3 fall off; misalignment is left to software.
    assign w_sel   = w_sel_base << w_result[1:0];
    assign w_wdata = rs2_val_i << {w_result[1:0], 3'b000};

    // Output slot: load on accept, drain on leave, hold on stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            output_valid_o  <= 1'b0;
            alu_result_o    <= 32'd0;
            enable_o        <= 1'b0;
            write_o         <= 1'b0;
            write_data_o    <= 32'd0;
            sel_o           <= 4'd0;
            unsigned_load_o <= 1'b0;
            reg_write_o     <= 1'b0;
            reg_addr_o      <= 5'd0;
            branch_o        <= 1'b0;
            branch_target_o <= 32'd0;
        end else if (w_accept) begin
            output_valid_o  <= 1'b1;
            alu_result_o    <= w_result;
            enable_o        <= ls_enable_i;
            write_o         <= ls_write_i;
            write_data_o    <= w_wdata;
            sel_o           <= w_sel;
            unsigned_load_o <= ls_unsigned_i;
            reg_write_o     <= reg_write_i;
            reg_addr_o      <= reg_addr_i;
            branch_o        <= w_taken;
            branch_target_o <= w_target;
        end else begin
            // Redirect is a single pulse; never repeated while stalled.
            branch_o <= 1'b0;
            if (output_valid_o && output_ready_i)
                output_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage.
module tb_execute;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_ready_o;
    logic        input_valid_i;
    logic [31:0] pc_i, rs1_val_i, rs2_val_i, imm_i;
    logic        op1_pc_i, op2_imm_i;
    logic [2:0]  alu_ctrl_i;
    logic        alu_alt_i, result_pc4_i;
    logic [2:0]  branch_cond_i;
    logic        jalr_i, ls_enable_i, ls_write_i, ls_unsigned_i;
    logic [1:0]  ls_size_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic        output_ready_i;
    logic        output_valid_o;
    logic [31:0] alu_result_o;
    logic        enable_o, write_o;
    logic [31:0] write_data_o;
    logic [3:0]  sel_o;
    logic        unsigned_load_o, reg_write_o;
    logic [4:0]  reg_addr_o;
    logic        branch_o;
    logic [31:0] branch_target_o;

    int checks   = 0;
    int failures = 0;

    execute dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
        .pc_i(pc_i), .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .imm_i(imm_i),
        .op1_pc_i(op1_pc_i), .op2_imm_i(op2_imm_i),
        .alu_ctrl_i(alu_ctrl_i), .alu_alt_i(alu_alt_i), .result_pc4_i(result_pc4_i),
        .branch_cond_i(branch_cond_i), .jalr_i(jalr_i),
        .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i),
        .ls_unsigned_i(ls_unsigned_i), .ls_size_i(ls_size_i),
        .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .output_ready_i(output_ready_i), .output_valid_o(output_valid_o),
        .alu_result_o(alu_result_o), .enable_o(enable_o), .write_o(write_o),
        .write_data_o(write_data_o), .sel_o(sel_o),
        .unsigned_load_o(unsigned_load_o), .reg_write_o(reg_write_o),
        .reg_addr_o(reg_addr_o), .branch_o(branch_o),
        .branch_target_o(branch_target_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Idle instruction: add rs1+rs2, no memory access, no branch.
    task automatic clear_in();
        input_valid_i = 0; pc_i = 0; rs1_val_i = 0; rs2_val_i = 0; imm_i = 0;
        op1_pc_i = 0; op2_imm_i = 0; alu_ctrl_i = 0; alu_alt_i = 0;
        result_pc4_i = 0; branch_cond_i = 0; jalr_i = 0;
        ls_enable_i = 0; ls_write_i = 0; ls_unsigned_i = 0; ls_size_i = 0;
        reg_write_i = 0; reg_addr_i = 0;
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        clear_in();
        output_ready_i = 1;
        rst_i = 1;
        step(); step();
        chk("rst_valid",  {31'd0, output_valid_o}, 0);
        chk("rst_branch", {31'd0, branch_o}, 0);
        chk("rst_alu",    alu_result_o, 0);
        chk("rst_wdata",  write_data_o, 0);
        chk("rst_sel",    {28'd0, sel_o}, 0);
        chk("rst_target", branch_target_o, 0);
        chk("rst_regaddr", {27'd0, reg_addr_o}, 0);
        chk("rst_ready",  {31'd0, input_ready_o}, 1);
        rst_i = 0;

        // add 5+7
        clear_in(); input_valid_i = 1; rs1_val_i = 5; rs2_val_i = 7;
        reg_write_i = 1; reg_addr_i = 5'd3;
        step();
        chk("add", alu_result_o, 32'd12);
        chk("add_valid", {31'd0, output_valid_o}, 1);
        chk("add_branch", {31'd0, branch_o}, 0);
        chk("add_regw", {31'd0, reg_write_o}, 1);
        chk("add_regaddr", {27'd0, reg_addr_o}, 3);

        // sub 5-7
        alu_alt_i = 1;
        step();
        chk("sub", alu_result_o, 32'hFFFFFFFE);

        // sra / srl with immediate 4
        clear_in(); input_valid_i = 1; rs1_val_i = 32'h80000000; imm_i = 4;
        op2_imm_i = 1; alu_ctrl_i = 3'b101; alu_alt_i = 1;
        step();
        chk("sra", alu_result_o, 32'hF8000000);
        alu_alt_i = 0;
        step();
        chk("srl", alu_result_o, 32'h08000000);

        // sll uses only b[4:0]: 0x23 -> shift by 3
        clear_in(); input_valid_i = 1; rs1_val_i = 1; rs2_val_i = 32'h23; alu_ctrl_i = 3'b001;
        step();
        chk("sll", alu_result_o, 32'd8);

        // slt / sltu with -3 vs 2
        clear_in(); input_valid_i = 1; rs1_val_i = 32'hFFFFFFFD; rs2_val_i = 2; alu_ctrl_i = 3'b010;
        step();
        chk("slt", alu_result_o, 32'd1);
        alu_ctrl_i = 3'b011;
        step();
        chk("sltu", alu_result_o, 32'd0);

        // or / and
        clear_in(); input_valid_i = 1; rs1_val_i = 32'hF0F0; rs2_val_i = 32'h0FF0; alu_ctrl_i = 3'b110;
        step();
        chk("or", alu_result_o, 32'hFFF0);
        alu_ctrl_i = 3'b111;
        step();
        chk("and", alu_result_o, 32'h00F0);

        // store byte at 0x103
        clear_in(); input_valid_i = 1; rs1_val_i = 32'h100; imm_i = 3; op2_imm_i = 1;
        rs2_val_i = 32'hAB; ls_size_i = 2'b00; ls_write_i = 1; ls_enable_i = 1;
        step();
        chk("sb_addr",  alu_result_o, 32'h103);
        chk("sb_sel",   {28'd0, sel_o}, 32'h8);
        chk("sb_wdata", write_data_o, 32'hAB000000);
        chk("sb_en",    {31'd0, enable_o}, 1);
        chk("sb_wr",    {31'd0, write_o}, 1);

        // store half at 0x102
        imm_i = 2; rs2_val_i = 32'h1234; ls_size_i = 2'b01;
        step();
        chk("sh_sel",   {28'd0, sel_o}, 32'hC);
        chk("sh_wdata", write_data_o, 32'h12340000);

        // unsigned word load, size 11 behaves as word
        ls_write_i = 0; ls_unsigned_i = 1; ls_size_i = 2'b11; imm_i = 0;
        step();
        chk("lw_sel", {28'd0, sel_o}, 32'hF);
        chk("lw_uns", {31'd0, unsigned_load_o}, 1);
        chk("lw_wr",  {31'd0, write_o}, 0);

        // blt -1 < 1 taken
        clear_in(); input_valid_i = 1; pc_i = 32'h1000; imm_i = 32'h20;
        rs1_val_i = 32'hFFFFFFFF; rs2_val_i = 1; branch_cond_i = 3'd3;
        step();
        chk("blt_branch", {31'd0, branch_o}, 1);
        chk("blt_target", branch_target_o, 32'h1020);
        input_valid_i = 0;
        step();
        chk("blt_pulse", {31'd0, branch_o}, 0);
        chk("idle_valid", {31'd0, output_valid_o}, 0);
        chk("idle_target", branch_target_o, 32'h1020);

        // bltu 0xFFFFFFFF < 1 not taken
        input_valid_i = 1; branch_cond_i = 3'd5;
        step();
        chk("bltu_branch", {31'd0, branch_o}, 0);
        chk("bltu_valid", {31'd0, output_valid_o}, 1);

        // jalr
        clear_in(); input_valid_i = 1; pc_i = 32'h40; rs1_val_i = 32'h201; imm_i = 0;
        result_pc4_i = 1; jalr_i = 1; branch_cond_i = 3'd7;
        step();
        chk("jalr_branch", {31'd0, branch_o}, 1);
        chk("jalr_target", branch_target_o, 32'h200);
        chk("jalr_link",   alu_result_o, 32'h44);

        // backpressure: beq 9==9 taken, alu 18
        clear_in(); input_valid_i = 1; pc_i = 32'h300; imm_i = 32'h10;
        rs1_val_i = 9; rs2_val_i = 9; branch_cond_i = 3'd1;
        step();
        chk("bp_a_alu", alu_result_o, 32'd18);
        chk("bp_a_branch", {31'd0, branch_o}, 1);
        // present B (1+2) while lsm stalls
        clear_in(); input_valid_i = 1; rs1_val_i = 1; rs2_val_i = 2;
        output_ready_i = 0;
        #1;
        chk("bp_ready_low", {31'd0, input_ready_o}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_alu", alu_result_o, 32'd18);
            chk("bp_hold_branch", {31'd0, branch_o}, 0);
            chk("bp_hold_valid", {31'd0, output_valid_o}, 1);
            chk("bp_hold_target", branch_target_o, 32'h310);
            chk("bp_hold_ready", {31'd0, input_ready_o}, 0);
        end
        output_ready_i = 1;
        #1;
        chk("bp_ready_back", {31'd0, input_ready_o}, 1);
        step();
        chk("bp_b_alu", alu_result_o, 32'd3);
        // C: xor
        rs1_val_i = 32'hF0; rs2_val_i = 32'hFF; alu_ctrl_i = 3'b100;
        step();
        chk("bp_c_alu", alu_result_o, 32'h0F);
        chk("bp_c_valid", {31'd0, output_valid_o}, 1);
        input_valid_i = 0;
        step();
        chk("bp_drain", {31'd0, output_valid_o}, 0);

        // reset during stall
        clear_in(); input_valid_i = 1; rs1_val_i = 32'h55; ls_enable_i = 1; ls_size_i = 2'b10;
        branch_cond_i = 3'd7; imm_i = 32'h8;
        step();
        chk("rs_pre_valid", {31'd0, output_valid_o}, 1);
        output_ready_i = 0;
        step();
        chk("rs_stall_alu", alu_result_o, 32'h55);
        rst_i = 1;
        step();
        chk("rs_valid",  {31'd0, output_valid_o}, 0);
        chk("rs_alu",    alu_result_o, 0);
        chk("rs_sel",    {28'd0, sel_o}, 0);
        chk("rs_en",     {31'd0, enable_o}, 0);
        chk("rs_branch", {31'd0, branch_o}, 0);
        chk("rs_target", branch_target_o, 0);
        chk("rs_ready",  {31'd0, input_ready_o}, 1);
        rst_i = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
